// File: rtl/next_pc_unit_pkg.sv
// Shared encodings and defaults for the next-PC selection logic.
package next_pc_unit_pkg;

   // PCSrc encodings
   localparam logic [2:0] PC_SEQ  = 3'b000;
   localparam logic [2:0] PC_BR   = 3'b001;
   localparam logic [2:0] PC_JAL  = 3'b010;
   localparam logic [2:0] PC_JALR = 3'b011;
   localparam logic [2:0] PC_TRAP = 3'b100;
   localparam logic [2:0] PC_PEND = 3'b101;

   // Default reset and trap addresses
   localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
   localparam logic [31:0] DEF_TRAP_VEC = 32'h0000_0100;

endpackage

// File: rtl/next_pc_unit_prio.sv
// Fixed-priority source select with JALR LSB clear and misaligned-target trapping.
module next_pc_unit_prio
   import next_pc_unit_pkg::*;
#(
   parameter int unsigned     XLEN       = 32,
   parameter logic [XLEN-1:0] TRAP_VEC   = XLEN'(DEF_TRAP_VEC),
   parameter int unsigned     ILEN_BYTES = 4
) (
   input  logic            takebranch,
   input  logic            branch,
   input  logic            jump,
   input  logic            jalr,
   input  logic            trap,
   input  logic [XLEN-1:0] pc_tgt,
   input  logic [XLEN-1:0] jalr_tgt,
   input  logic [XLEN-1:0] seq_tgt,
   output logic [2:0]      src,
   output logic [XLEN-1:0] tgt,
   output logic            misalign,
   output logic            redirect
);

   logic [XLEN-1:0] jalr_clr;
   assign jalr_clr = {jalr_tgt[XLEN-1:1], 1'b0};

   // Priority: trap > jalr > jump > taken branch > seq; misaligned targets become traps
   always_comb begin
      src      = PC_SEQ;
      tgt      = seq_tgt;
      misalign = 1'b0;
      if (trap) begin
         src = PC_TRAP;
         tgt = TRAP_VEC;
      end else if (jalr) begin
         src = PC_JALR;
         tgt = jalr_clr;
      end else if (jump) begin
         src = PC_JAL;
         tgt = pc_tgt;
      end else if (branch && takebranch) begin
         src = PC_BR;
         tgt = pc_tgt;
      end
      // Only non-trap redirects are checked; 2-byte instructions never misalign
      if (ILEN_BYTES == 4 && src != PC_SEQ && src != PC_TRAP && tgt[1]) begin
         misalign = 1'b1;
         src      = PC_TRAP;
         tgt      = TRAP_VEC;
      end
      redirect = (src != PC_SEQ);
   end

endmodule

// File: rtl/next_pc_unit.sv
// Program-counter register with prioritised redirects, stall-held pending redirect
// and a registered one-cycle flush pulse.
module next_pc_unit
   import next_pc_unit_pkg::*;
#(
   parameter int unsigned     XLEN       = 32,
   parameter logic [XLEN-1:0] RESET_PC   = XLEN'(DEF_RESET_PC),
   parameter logic [XLEN-1:0] TRAP_VEC   = XLEN'(DEF_TRAP_VEC),
   parameter int unsigned     ILEN_BYTES = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall,
   input  logic            takebranch,
   input  logic            branch,
   input  logic            jump,
   input  logic            jalr,
   input  logic            trap,
   input  logic [XLEN-1:0] pc_tgt,
   input  logic [XLEN-1:0] jalr_tgt,
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] pc_next_seq,
   output logic [2:0]      PCSrc,
   output logic            flush,
   output logic            misalign,
   output logic            pend_valid
);

   logic [2:0]      sel_src;
   logic [XLEN-1:0] sel_tgt;
   logic            sel_misalign;
   logic            sel_redirect;
   logic [XLEN-1:0] pend_tgt;

   // Wraps modulo 2^XLEN
   assign pc_next_seq = pc + XLEN'(ILEN_BYTES);

   next_pc_unit_prio #(
      .XLEN       (XLEN),
      .TRAP_VEC   (TRAP_VEC),
      .ILEN_BYTES (ILEN_BYTES)
   ) u_prio (
      .takebranch (takebranch),
      .branch     (branch),
      .jump       (jump),
      .jalr       (jalr),
      .trap       (trap),
      .pc_tgt     (pc_tgt),
      .jalr_tgt   (jalr_tgt),
      .seq_tgt    (pc_next_seq),
      .src        (sel_src),
      .tgt        (sel_tgt),
      .misalign   (sel_misalign),
      .redirect   (sel_redirect)
   );

   // Reported source: a release cycle shows the pending redirect unless a new trap wins
   always_comb begin
      PCSrc    = sel_src;
      misalign = sel_misalign & ~pend_valid;
      if (pend_valid && !stall) begin
         PCSrc = trap ? PC_TRAP : PC_PEND;
      end
   end

   // PC, pending holder and flush registers
   always_ff @(posedge clk) begin
      if (rst) begin
         pc         <= RESET_PC;
         flush      <= 1'b0;
         pend_valid <= 1'b0;
         pend_tgt   <= '0;
      end else if (stall) begin
         flush <= 1'b0;
         if (!pend_valid && sel_redirect) begin
            pend_tgt   <= sel_tgt;
            pend_valid <= 1'b1;
         end else if (pend_valid && trap) begin
            pend_tgt <= TRAP_VEC;
         end
      end else if (pend_valid) begin
         // Older pending redirect beats any new non-trap redirect
         pc         <= trap ? TRAP_VEC : pend_tgt;
         flush      <= 1'b1;
         pend_valid <= 1'b0;
      end else begin
         pc    <= sel_tgt;
         flush <= sel_redirect;
      end
   end

endmodule

// File: tb/tb_next_pc_unit.sv
// Directed self-checking bench for next_pc_unit.
module tb_next_pc_unit;

   logic        clk = 1'b0;
   logic        rst, stall, takebranch, branch, jump, jalr, trap;
   logic [31:0] pc_tgt, jalr_tgt;
   logic [31:0] pc, pc_next_seq;
   logic [2:0]  PCSrc;
   logic        flush, misalign, pend_valid;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   next_pc_unit #(
      .XLEN       (32),
      .RESET_PC   (32'h0000_0000),
      .TRAP_VEC   (32'h0000_0100),
      .ILEN_BYTES (4)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .stall       (stall),
      .takebranch  (takebranch),
      .branch      (branch),
      .jump        (jump),
      .jalr        (jalr),
      .trap        (trap),
      .pc_tgt      (pc_tgt),
      .jalr_tgt    (jalr_tgt),
      .pc          (pc),
      .pc_next_seq (pc_next_seq),
      .PCSrc       (PCSrc),
      .flush       (flush),
      .misalign    (misalign),
      .pend_valid  (pend_valid)
   );

   task automatic clear_req();
      takebranch = 0; branch = 0; jump = 0; jalr = 0; trap = 0;
      pc_tgt = '0; jalr_tgt = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1; stall = 0; clear_req();
      tick(); tick();
      total++; if (pc !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h exp=%h", pc, 32'h0); end
      total++; if (flush !== 1'b0) begin bad++; $display("FAIL reset_flush got=%b exp=0", flush); end
      total++; if (pend_valid !== 1'b0) begin bad++; $display("FAIL reset_pend got=%b exp=0", pend_valid); end
      rst = 0; #1;
      total++; if (PCSrc !== 3'b000) begin bad++; $display("FAIL reset_src got=%b exp=000", PCSrc); end
      tick();
      total++; if (pc !== 32'h4) begin bad++; $display("FAIL seq_pc1 got=%h exp=%h", pc, 32'h4); end
      tick();
      total++; if (pc !== 32'h8) begin bad++; $display("FAIL seq_pc2 got=%h exp=%h", pc, 32'h8); end
      total++; if (flush !== 1'b0) begin bad++; $display("FAIL seq_flush got=%b exp=0", flush); end
   endtask

   task automatic test_priority();
      tick(); tick(); // pc = 0x10
      total++; if (pc !== 32'h10) begin bad++; $display("FAIL prio_start got=%h exp=%h", pc, 32'h10); end
      branch = 1; takebranch = 1; jump = 1; pc_tgt = 32'h40; jalr = 1; jalr_tgt = 32'h81;
      #1;
      total++; if (PCSrc !== 3'b011) begin bad++; $display("FAIL prio_src got=%b exp=011", PCSrc); end
      total++; if (misalign !== 1'b0) begin bad++; $display("FAIL prio_misalign got=%b exp=0", misalign); end
      tick();
      total++; if (pc !== 32'h80) begin bad++; $display("FAIL jalr_pc got=%h exp=%h", pc, 32'h80); end
      total++; if (flush !== 1'b1) begin bad++; $display("FAIL jalr_flush got=%b exp=1", flush); end
      clear_req();
      tick();
      total++; if (pc !== 32'h84) begin bad++; $display("FAIL after_jalr_pc got=%h exp=%h", pc, 32'h84); end
      total++; if (flush !== 1'b0) begin bad++; $display("FAIL flush_once got=%b exp=0", flush); end
      takebranch = 1; #1;
      total++; if (PCSrc !== 3'b000) begin bad++; $display("FAIL tb_only_src got=%b exp=000", PCSrc); end
      tick();
      total++; if (pc !== 32'h88) begin bad++; $display("FAIL tb_only_pc got=%h exp=%h", pc, 32'h88); end
      branch = 1; pc_tgt = 32'h60; #1;
      total++; if (PCSrc !== 3'b001) begin bad++; $display("FAIL br_src got=%b exp=001", PCSrc); end
      tick();
      total++; if (pc !== 32'h60) begin bad++; $display("FAIL br_pc got=%h exp=%h", pc, 32'h60); end
      clear_req();
   endtask

   task automatic test_misalign();
      jump = 1; pc_tgt = 32'h22; #1;
      total++; if (misalign !== 1'b1) begin bad++; $display("FAIL mis_flag got=%b exp=1", misalign); end
      total++; if (PCSrc !== 3'b100) begin bad++; $display("FAIL mis_src got=%b exp=100", PCSrc); end
      tick();
      total++; if (pc !== 32'h100) begin bad++; $display("FAIL mis_pc got=%h exp=%h", pc, 32'h100); end
      total++; if (flush !== 1'b1) begin bad++; $display("FAIL mis_flush got=%b exp=1", flush); end
      clear_req();
      tick();
      total++; if (pc !== 32'h104) begin bad++; $display("FAIL mis_after got=%h exp=%h", pc, 32'h104); end
   endtask

   task automatic test_stall();
      stall = 1; jump = 1; pc_tgt = 32'h200; #1;
      total++; if (PCSrc !== 3'b010) begin bad++; $display("FAIL st_src got=%b exp=010", PCSrc); end
      tick();
      total++; if (pc !== 32'h104) begin bad++; $display("FAIL st_hold1 got=%h exp=%h", pc, 32'h104); end
      total++; if (pend_valid !== 1'b1) begin bad++; $display("FAIL st_pend1 got=%b exp=1", pend_valid); end
      jump = 0; branch = 1; takebranch = 1; pc_tgt = 32'h300;
      tick();
      total++; if (pc !== 32'h104) begin bad++; $display("FAIL st_hold2 got=%h exp=%h", pc, 32'h104); end
      clear_req();
      tick();
      total++; if (flush !== 1'b0) begin bad++; $display("FAIL st_flush got=%b exp=0", flush); end
      stall = 0; #1;
      total++; if (PCSrc !== 3'b101) begin bad++; $display("FAIL rel_src got=%b exp=101", PCSrc); end
      tick();
      total++; if (pc !== 32'h200) begin bad++; $display("FAIL rel_pc got=%h exp=%h", pc, 32'h200); end
      total++; if (flush !== 1'b1) begin bad++; $display("FAIL rel_flush got=%b exp=1", flush); end
      total++; if (pend_valid !== 1'b0) begin bad++; $display("FAIL rel_pend got=%b exp=0", pend_valid); end
      tick();
      total++; if (flush !== 1'b0) begin bad++; $display("FAIL rel_flush_once got=%b exp=0", flush); end
   endtask

   task automatic test_trap_override();
      // Trap during the stall overwrites the pending target
      stall = 1; jump = 1; pc_tgt = 32'h200;
      tick();
      jump = 0; trap = 1;
      tick();
      trap = 0; stall = 0;
      tick();
      total++; if (pc !== 32'h100) begin bad++; $display("FAIL trap_pend_pc got=%h exp=%h", pc, 32'h100); end
      // Trap on the release cycle itself
      stall = 1; jump = 1; pc_tgt = 32'h200;
      tick();
      jump = 0; stall = 0; trap = 1; #1;
      total++; if (PCSrc !== 3'b100) begin bad++; $display("FAIL trap_rel_src got=%b exp=100", PCSrc); end
      tick();
      total++; if (pc !== 32'h100) begin bad++; $display("FAIL trap_rel_pc got=%h exp=%h", pc, 32'h100); end
      trap = 0;
      // Reset mid-stall drops the pending redirect
      stall = 1; jump = 1; pc_tgt = 32'h200;
      tick();
      rst = 1;
      tick();
      total++; if (pc !== 32'h0) begin bad++; $display("FAIL rst_stall_pc got=%h exp=%h", pc, 32'h0); end
      total++; if (pend_valid !== 1'b0) begin bad++; $display("FAIL rst_stall_pend got=%b exp=0", pend_valid); end
      rst = 0; stall = 0; clear_req();
      tick();
      total++; if (pc !== 32'h4) begin bad++; $display("FAIL rst_stall_after got=%h exp=%h", pc, 32'h4); end
      total++; if (flush !== 1'b0) begin bad++; $display("FAIL rst_stall_flush got=%b exp=0", flush); end
   endtask

   task automatic test_back_to_back();
      // Pending redirect wins over a new non-trap redirect on release
      stall = 1; jalr = 1; jalr_tgt = 32'h405;
      tick();
      total++; if (pend_valid !== 1'b1) begin bad++; $display("FAIL b2b_pend got=%b exp=1", pend_valid); end
      jalr = 0; stall = 0; jump = 1; pc_tgt = 32'h300;
      tick();
      total++; if (pc !== 32'h404) begin bad++; $display("FAIL b2b_pc got=%h exp=%h", pc, 32'h404); end
      // Immediate redirect on the cycle after release
      pc_tgt = 32'h500;
      tick();
      total++; if (pc !== 32'h500) begin bad++; $display("FAIL b2b_next got=%h exp=%h", pc, 32'h500); end
      total++; if (flush !== 1'b1) begin bad++; $display("FAIL b2b_flush got=%b exp=1", flush); end
      clear_req();
   endtask

   task automatic test_wrap();
      jump = 1; pc_tgt = 32'hFFFF_FFFC;
      tick();
      clear_req(); #1;
      total++; if (pc_next_seq !== 32'h0) begin bad++; $display("FAIL wrap_seq got=%h exp=%h", pc_next_seq, 32'h0); end
      tick();
      total++; if (pc !== 32'h0) begin bad++; $display("FAIL wrap_pc got=%h exp=%h", pc, 32'h0); end
   endtask

   initial begin
      test_reset();
      test_priority();
      test_misalign();
      test_stall();
      test_trap_override();
      test_back_to_back();
      test_wrap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/next_pc_unit.md
Name: next_pc_unit

Overview:
- Parametrised successor to the PC-source selector: owns the program-counter register and picks the next PC from sequential, branch, JAL, JALR and trap sources.
- Adds a fixed source priority, JALR LSB clearing, misaligned-target trapping, stall handling with a held pending redirect, and a registered one-cycle flush pulse.
- Sits between the IF stage (drives `pc`) and EX (supplies targets and the branch decision).

Parameters:
- XLEN, 32, datapath and PC width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- TRAP_VEC, 32'h0000_0100, redirect address for a trap or a misaligned target.
- ILEN_BYTES, 4, sequential increment; legal values are 2 and 4, and it also sets the alignment check.

Ports:
- clk, input, 1: clock, rising edge.
- rst, input, 1: synchronous, active-high reset.
- stall, input, 1: hold the PC this cycle.
- takebranch, input, 1: branch comparator result from EX.
- branch, input, 1: EX instruction is a conditional branch.
- jump, input, 1: EX instruction is JAL.
- jalr, input, 1: EX instruction is JALR.
- trap, input, 1: synchronous exception request.
- pc_tgt, input, XLEN: PC+imm target for branch and JAL.
- jalr_tgt, input, XLEN: raw rs1+imm for JALR.
- pc, output, XLEN: current fetch PC (registered).
- pc_next_seq, output, XLEN: pc + ILEN_BYTES (combinational).
- PCSrc, output, 3: selected source. 000 = seq, 001 = branch, 010 = jal, 011 = jalr, 100 = trap, 101 = pending.
- flush, output, 1: registered; high for exactly one cycle after a redirect is applied.
- misalign, output, 1: combinational; the chosen target violates alignment.
- pend_valid, output, 1: a redirect is being held across a stall.

Behaviour:
- Reset (sync, rst=1 at a clk edge):
  - pc = RESET_PC.
  - flush = 0, pend_valid = 0, pending target = 0.
  - rst has priority over every other input.
- Source priority, evaluated combinationally each cycle: trap > jalr > jump > (branch & takebranch) > seq.
  - takebranch with branch=0 is ignored; this replaces the old don't-care default.
  - Multiple asserted requests resolve by this priority. They never fall back to seq.
- JALR target is jalr_tgt with bit 0 forced to 0.
- Misalignment:
  - For ILEN_BYTES=4, the chosen non-seq target with bit 1 set is misaligned.
  - For ILEN_BYTES=2, no target is ever misaligned.
  - misalign=1 makes the redirect go to TRAP_VEC and sets PCSrc=100.
  - misalign is only meaningful when PCSrc != 000; it is 0 otherwise.
- "Redirect" means any selected source other than seq.
- Normal cycle (stall=0, pend_valid=0):
  - pc <= the selected target on the next edge. Latency is 1 cycle.
  - On a redirect, flush <= 1 for the next cycle; otherwise flush <= 0.
- Stall cycle (stall=1): pc holds, flush <= 0.
  - If a redirect is present and pend_valid=0: capture the resolved target (post-JALR-clear, post-misalign) and set pend_valid.
  - If pend_valid=1: further redirects are ignored, except trap, which overwrites the pending target with TRAP_VEC.
- Release cycle (stall=0, pend_valid=1):
  - PCSrc=101, pc <= pending target, flush <= 1, pend_valid <= 0.
  - A simultaneous new trap overrides and goes to TRAP_VEC.
  - Any other simultaneous redirect is dropped; the older pending redirect wins.
- Arithmetic: pc + ILEN_BYTES wraps modulo 2^XLEN with no carry out. All adds are XLEN wide.
- rst asserted while pend_valid=1 clears the pending state; there is no residual flush.

Decomposition:
- Shared package (rv_pkg), which lives outside this block:
  - PCSrc encodings as localparams: PC_SEQ, PC_BR, PC_JAL, PC_JALR, PC_TRAP, PC_PEND.
  - Default RESET_PC and TRAP_VEC.
- One natural sub-module: pc_src_prio, the purely combinational priority encoder plus JALR clear and misalign check. It produces the selected source and target.
- next_pc_unit keeps the PC register, the pending holder and the flush register.

Test Plan:
- Reset release: rst=1 for 2 cycles, then 0 with no requests. Required: pc = 0x0, 0x4, 0x8; PCSrc=000; flush=0.
- Priority: at pc=0x10, assert branch=1, takebranch=1, jump=1, pc_tgt=0x40, jalr=1, jalr_tgt=0x81. Required: PCSrc=011; next pc=0x80; flush=1 for one cycle. Separately, takebranch=1 with branch=0 gives PCSrc=000.
- Misalign: jump=1, pc_tgt=0x22 (ILEN_BYTES=4). Required: misalign=1, PCSrc=100, next pc=0x100, flush pulse.
- Stall capture: stall=1 for 3 cycles. Cycle 1 has jump=1, pc_tgt=0x200; cycle 2 has branch&takebranch with pc_tgt=0x300. Required: pc held; pend_valid=1 from cycle 2. On release, PCSrc=101, pc=0x200, flush=1 once, pend_valid=0.
- Trap override: pending 0x200, then trap=1 during stall. Required: released pc=0x100. Also rst mid-stall gives pc=RESET_PC with pend_valid=0.
- Wrap: force pc=0xFFFF_FFFC with no requests. Required: next pc=0x0000_0000.
